serial_adder: RTL



---
 rtl/adder_pkg.sv | 15 +
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder: FSM state encoding and counter sizing.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..n without wrapping inside one operation.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder stages; chained by serial_adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   // First half adder: a + b; second half adder: partial sum + cin.
   assign s1   = a ^ b;
   assign c1   = a & b;
   assign sum  = s1 ^ cin;
   assign c2   = s1 & cin;
   assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder processing DIGIT bits per clock with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: DIGIT must divide WIDTH exactly");
   end

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] dsum;
   logic [DIGIT:0]   chain;
   logic             accept;
   logic             last;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == CW'(N - 1));
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // Per-cycle digit adder: DIGIT full adders in a ripple chain.
   assign chain[0] = carry;
   for (genvar g = 0; g < DIGIT; g++) begin : g_fa
      full_adder u_fa (
         .a   (a_sh[g]),
         .b   (b_sh[g]),
         .cin (chain[g]),
         .sum (dsum[g]),
         .cout(chain[g+1])
      );
   end

   // New digit enters at the top so the LSB digit ends at bit 0 after N cycles.
   if (N == 1) begin : g_acc_single
      assign acc_next = dsum;
   end else begin : g_acc_shift
      assign acc_next = {dsum, acc[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> DIGIT;
         b_sh  <= b_sh >> DIGIT;
         acc   <= acc_next;
         carry <= chain[DIGIT];
         cnt   <= cnt + CW'(1);
         if (last) begin
            sum  <= acc_next;
            cout <= chain[DIGIT];
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic a_msb;
   logic b_msb;

   // Operand MSBs are shifted out during RUN, so keep a copy for the overflow rule.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (last) begin
         ovf <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
      end
   end
`endif

endmodule
